// File: rtl/first_nios2_system_sysinfo_pkg.sv
// Register map, CTRL bit positions and reset values shared by the sysinfo slave.
// Pure declarations: no state, no latency, no flow control.
// Helper functions for CTRL packing and byte-lane merging.
package first_nios2_system_sysinfo_pkg;

  localparam int unsigned OFF_ID             = 0;
  localparam int unsigned OFF_TIMESTAMP      = 1;
  localparam int unsigned OFF_UPTIME_LO      = 2;
  localparam int unsigned OFF_UPTIME_HI_SNAP = 3;
  localparam int unsigned OFF_CTRL           = 4;
  localparam int unsigned OFF_ALARM          = 5;
  localparam int unsigned OFF_SCRATCH_BASE   = 6;

  localparam int unsigned CTRL_RUN    = 0;
  localparam int unsigned CTRL_CLEAR  = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;
  localparam int unsigned CTRL_ALARM  = 3;

  localparam logic [31:0] CTRL_RESET  = 32'h0000_0001;
  localparam logic [31:0] ALARM_RESET = 32'hFFFF_FFFF;

  // Only the stored CTRL bits; clear is a strobe and never held.
  typedef struct packed {
    logic alarm;
    logic irq_en;
    logic run;
  } ctrl_t;

  function automatic logic [31:0] ctrl_word(input ctrl_t c);
    logic [31:0] w;
    w              = '0;
    w[CTRL_RUN]    = c.run;
    w[CTRL_IRQ_EN] = c.irq_en;
    w[CTRL_ALARM]  = c.alarm;
    return w;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_val[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/first_nios2_system_sysinfo_uptime.sv
// Prescaler plus free-running 64-bit uptime counter.
// Latency: uptime updates on the tick edge; tick is combinational from registers.
// Backpressure: none; run=0 freezes both counters, clear zeroes them.
module first_nios2_system_sysinfo_uptime
  import first_nios2_system_sysinfo_pkg::*;
#(
  parameter int PRESCALE = 50
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        run,
  input  logic        clear,
  output logic [63:0] uptime,
  output logic        tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre_q;
  logic [63:0]   cnt_q;
  logic          wrap;

  assign wrap   = (pre_q == PW'(PRESCALE - 1));
  // A clear in the same cycle wins, so the tick is not reported to the alarm.
  assign tick   = run && wrap && !clear;
  assign uptime = cnt_q;

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else if (run) begin
      pre_q <= wrap ? '0 : pre_q + PW'(1);
      if (wrap) cnt_q <= cnt_q + 64'd1;
    end
  end

endmodule

// File: rtl/first_nios2_system_sysinfo.sv
// Avalon-MM system info slave: ID, timestamp, uptime, alarm irq, scratch registers.
// Latency: fixed one-cycle registered read data, writes land on the write-cycle edge.
// Backpressure: none (no waitrequest); a read may be issued every cycle.
module first_nios2_system_sysinfo
  import first_nios2_system_sysinfo_pkg::*;
#(
  parameter logic [31:0] SYSID_ID        = 32'd1,
  parameter logic [31:0] SYSID_TIMESTAMP = 32'd1433419009,
  parameter int          ADDR_W          = 3,
  parameter int          NUM_SCRATCH     = 2,
  parameter int          PRESCALE        = 50
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid,
  output logic              irq
);

  localparam int NS = (NUM_SCRATCH > 0) ? NUM_SCRATCH : 1;

  logic [63:0] uptime;
  logic        tick;
  ctrl_t       ctrl_q;
  logic [31:0] alarm_q;
  logic [31:0] snap_q;
  logic [31:0] scratch_q [NS];
  logic [31:0] rd_val;
  logic        wr_ctrl;
  logic        wr_alarm;
  logic        rd_lo;
  logic        clear;
  logic        w1c;
  logic        alarm_hit;

  assign wr_ctrl  = write && (address == ADDR_W'(OFF_CTRL));
  assign wr_alarm = write && (address == ADDR_W'(OFF_ALARM));
  assign rd_lo    = read  && (address == ADDR_W'(OFF_UPTIME_LO));
  assign clear    = wr_ctrl && writedata[CTRL_CLEAR];
  assign w1c      = wr_ctrl && writedata[CTRL_ALARM];

  // Compare the value the counter is about to take against the pre-write ALARM.
  assign alarm_hit = tick && ((uptime[31:0] + 32'd1) == alarm_q);
  assign irq       = ctrl_q.alarm && ctrl_q.irq_en;

  first_nios2_system_sysinfo_uptime #(
    .PRESCALE (PRESCALE)
  ) u_uptime (
    .clock   (clock),
    .reset_n (reset_n),
    .run     (ctrl_q.run),
    .clear   (clear),
    .uptime  (uptime),
    .tick    (tick)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ctrl_q.run    <= CTRL_RESET[CTRL_RUN];
      ctrl_q.irq_en <= CTRL_RESET[CTRL_IRQ_EN];
      ctrl_q.alarm  <= CTRL_RESET[CTRL_ALARM];
      alarm_q       <= ALARM_RESET;
    end else begin
      if (wr_ctrl) begin
        ctrl_q.run    <= writedata[CTRL_RUN];
        ctrl_q.irq_en <= writedata[CTRL_IRQ_EN];
      end
      // Hardware set dominates a simultaneous write-1-to-clear.
      ctrl_q.alarm <= (ctrl_q.alarm && !w1c) || alarm_hit;
      if (wr_alarm) alarm_q <= writedata;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NS; i++) scratch_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (write && (address == ADDR_W'(OFF_SCRATCH_BASE + i)))
          scratch_q[i] <= merge_bytes(scratch_q[i], writedata, byteenable);
      end
    end
  end

  always_comb begin
    rd_val = '0;
    if (address == ADDR_W'(OFF_ID))                  rd_val = SYSID_ID;
    else if (address == ADDR_W'(OFF_TIMESTAMP))      rd_val = SYSID_TIMESTAMP;
    else if (address == ADDR_W'(OFF_UPTIME_LO))      rd_val = uptime[31:0];
    else if (address == ADDR_W'(OFF_UPTIME_HI_SNAP)) rd_val = snap_q;
    else if (address == ADDR_W'(OFF_CTRL))           rd_val = ctrl_word(ctrl_q);
    else if (address == ADDR_W'(OFF_ALARM))          rd_val = alarm_q;
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (address == ADDR_W'(OFF_SCRATCH_BASE + i)) rd_val = scratch_q[i];
    end
  end

  // The LO read latches the upper half of the same counter value for a coherent pair.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
      snap_q        <= '0;
    end else begin
      readdatavalid <= read;
      readdata      <= read ? rd_val : '0;
      if (rd_lo) snap_q <= uptime[63:32];
    end
  end

endmodule
